// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, runs one outstanding request at a
// time to variable-latency instruction memory and queues returned words for the decoder.
module ifetch #(
    parameter int AW    = 8,
    parameter int IW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          stall,
    output logic [IW-1:0] o,
    output logic          o_vld,
    output logic [AW-1:0] pc_o,
    input  logic          pcwe,
    input  logic          pcs,
    input  logic [AW-1:0] alu_y,
    input  logic [AW-1:0] jv,
    input  logic          h,
    output logic          halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_fpc;
    logic [AW-1:0] r_addr;
    logic          r_req;
    logic          r_halted;
    logic          r_discard;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_pc_mem [DEPTH];
    logic [IW-1:0] r_w_mem  [DEPTH];

    logic          w_vld;
    logic          w_take;
    logic          w_halt;
    logic          w_redir;
    logic          w_pop;
    logic          w_ack;
    logic          w_push;
    logic          w_issue;
    logic [AW-1:0] w_target;

    // The head may only act (retire, jump or halt) when it is real and the back end is not holding it.
    assign w_vld    = (r_count != {CW{1'b0}});
    assign w_take   = (r_state != S_HALT) && w_vld && !stall;
    assign w_halt   = w_take && h;
    assign w_redir  = w_take && pcwe && !h;
    assign w_pop    = w_take && !pcwe && !h;
    assign w_ack    = (r_state == S_WAIT) && imem_ack;
    assign w_push   = w_ack && !r_discard && !w_redir && !w_halt;
    assign w_issue  = (r_state == S_RUN) && (r_count < FULL) && !w_redir && !w_halt;
    assign w_target = pcs ? alu_y : jv;

    assign o_vld     = w_vld;
    assign o         = w_vld ? r_w_mem[r_rd_ptr] : {IW{1'b0}};
    assign pc_o      = w_vld ? r_pc_mem[r_rd_ptr] : r_fpc;
    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign halted    = r_halted;

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; halt is terminal until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_halt) begin
                    w_state_nxt = S_HALT;
                end else if (w_issue) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_WAIT: begin
                if (w_halt) begin
                    w_state_nxt = S_HALT;
                end else if (w_ack) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // PC, request, discard flag and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc     <= {AW{1'b0}};
            r_addr    <= {AW{1'b0}};
            r_req     <= 1'b0;
            r_halted  <= 1'b0;
            r_discard <= 1'b0;
            r_rd_ptr  <= {PW{1'b0}};
            r_wr_ptr  <= {PW{1'b0}};
            r_count   <= {CW{1'b0}};
        end else begin
            r_req    <= (w_state_nxt == S_WAIT);
            r_halted <= (w_state_nxt == S_HALT);
            if (w_issue) begin
                r_addr <= r_fpc;
            end
            if (w_redir) begin
                r_fpc <= w_target;
            end else if (w_push) begin
                r_fpc <= r_fpc + AW'(1);
            end
            // A jump while a read is in flight leaves a stale word to be dropped on arrival.
            if (w_halt || w_ack) begin
                r_discard <= 1'b0;
            end else if (w_redir && (r_state == S_WAIT)) begin
                r_discard <= 1'b1;
            end
            if (w_redir) begin
                r_rd_ptr <= {PW{1'b0}};
                r_wr_ptr <= {PW{1'b0}};
                r_count  <= {CW{1'b0}};
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr] <= r_fpc;
            r_w_mem[r_wr_ptr]  <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a queue-based fetch model is compared every cycle, and directed
// scenarios pin the retired instruction stream against hand-computed values.
module tb_ifetch;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] w;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic [15:0] o;
    logic        o_vld;
    logic [7:0]  pc_o;
    logic        pcwe;
    logic        pcs;
    logic [7:0]  alu_y;
    logic [7:0]  jv;
    logic        h;
    logic        halted;

    logic [15:0] mem [256];
    int          mem_lat;
    int          mem_cnt;
    logic        mem_ack_s;
    logic [15:0] mem_rdata_s;
    logic        force_ack;
    logic [15:0] force_rdata;
    logic        jmp_arm;
    logic [7:0]  jmp_pc;

    int n_checks = 0;
    int n_errors = 0;

    ent_t        mq[$];
    ent_t        lg[$];
    logic [7:0]  m_fpc;
    logic [7:0]  m_addr;
    bit          m_busy, m_drop, m_halt, m_valid;
    logic        s_rst, s_ack, s_stall, s_pcwe, s_pcs, s_h;
    logic [15:0] s_rd;
    logic [7:0]  s_alu, s_jv;
    logic [15:0] e_o;
    logic [7:0]  e_pc;
    logic        e_vld;
    int          cnt0;
    bit          take, ackv;

    ifetch #(.AW(8), .IW(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .o(o), .o_vld(o_vld), .pc_o(pc_o),
        .pcwe(pcwe), .pcs(pcs), .alu_y(alu_y), .jv(jv), .h(h), .halted(halted)
    );

    // Decoder stand-in: 0x0001 is HALT, jumps fire from one armed address.
    assign h          = o_vld && (o == 16'h0001);
    assign pcwe       = jmp_arm && o_vld && (pc_o == jmp_pc);
    assign imem_ack   = mem_ack_s | force_ack;
    assign imem_rdata = force_ack ? force_rdata : mem_rdata_s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: ack arrives in the mem_lat-th cycle that a request has been held.
    initial begin
        mem_ack_s = 1'b0;
        mem_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst || (imem_req !== 1'b1) || mem_ack_s) begin
                mem_ack_s = 1'b0;
                mem_cnt   = 0;
            end else begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) mem_ack_s = 1'b1;
            end
            mem_rdata_s = mem[imem_addr];
        end
    end

    // Model and per-cycle compare.
    initial begin
        m_valid = 0;
        forever begin
            @(negedge clk);
            #4;
            if (m_valid) begin
                e_vld = (mq.size() != 0);
                e_o   = e_vld ? mq[0].w : 16'h0000;
                e_pc  = e_vld ? mq[0].pc : m_fpc;
                chk("o_vld", 32'(o_vld), 32'(e_vld));
                chk("o", 32'(o), 32'(e_o));
                chk("pc_o", 32'(pc_o), 32'(e_pc));
                chk("imem_req", 32'(imem_req), 32'(m_busy && !m_halt));
                chk("imem_addr", 32'(imem_addr), 32'(m_addr));
                chk("halted", 32'(halted), 32'(m_halt));
                if (!m_halt && !rst && o_vld && !stall && (h || !pcwe)) lg.push_back({pc_o, o});
            end
            s_rst = rst; s_ack = imem_ack; s_rd = imem_rdata; s_stall = stall;
            s_pcwe = pcwe; s_pcs = pcs; s_alu = alu_y; s_jv = jv; s_h = h;
            @(posedge clk);
            if (s_rst) begin
                mq.delete();
                m_fpc = 8'h00; m_addr = 8'h00;
                m_busy = 0; m_drop = 0; m_halt = 0; m_valid = 1;
            end else if (m_valid && !m_halt) begin
                cnt0 = mq.size();
                take = (cnt0 != 0) && !s_stall;
                ackv = s_ack && m_busy;
                if (take && s_h) begin
                    m_halt = 1;
                end else if (take && s_pcwe) begin
                    mq.delete();
                    m_fpc = s_pcs ? s_alu : s_jv;
                    if (ackv) begin
                        m_busy = 0; m_drop = 0;
                    end else if (m_busy) begin
                        m_drop = 1;
                    end
                end else begin
                    if (take) void'(mq.pop_front());
                    if (ackv) begin
                        m_busy = 0;
                        if (m_drop) m_drop = 0;
                        else begin
                            mq.push_back({m_fpc, s_rd});
                            m_fpc = m_fpc + 8'd1;
                        end
                    end else if (!m_busy && cnt0 < DEPTH) begin
                        m_busy = 1;
                        m_addr = m_fpc;
                    end
                end
            end
        end
    end

    task automatic load_seq(input logic [15:0] base);
        for (int i = 0; i < 256; i++) mem[i] = base + 16'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lg.delete();
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_head(input logic [7:0] pc, input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (o_vld === 1'b1 && pc_o === pc) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL wait_head: pc %0h not at head within %0d cycles", pc, maxc);
        end
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [7:0] pc, input logic [15:0] w);
        ent_t e;
        e = (idx < lg.size()) ? lg[idx] : '0;
        chk(nm, 32'({e.pc, e.w}), 32'({pc, w}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; jmp_arm = 1'b0; jmp_pc = 8'h00;
        pcs = 1'b0; alu_y = 8'h00; jv = 8'h00;
        force_ack = 1'b0; force_rdata = 16'h0000; mem_lat = 1;

        // Straight-line program ending in HALT, 1-cycle memory.
        load_seq(16'h3000);
        mem[0] = 16'h8A12; mem[1] = 16'h8E34; mem[2] = 16'h0001;
        do_reset();
        run(20);
        chk("t1_log_size", 32'(lg.size()), 32'd3);
        chk_log("t1_w0", 0, 8'h00, 16'h8A12);
        chk_log("t1_w1", 1, 8'h01, 16'h8E34);
        chk_log("t1_w2", 2, 8'h02, 16'h0001);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_req_idle", 32'(imem_req), 32'd0);
        chk("t1_hold_o", 32'(o), 32'h0001);
        chk("t1_hold_vld", 32'(o_vld), 32'd1);

        // Relative jump at 0x05 to 0x03 while the fetch of 0x06 is in flight.
        load_seq(16'h1000);
        mem_lat = 3; jmp_pc = 8'h05; pcs = 1'b1; alu_y = 8'h03; jv = 8'h40; jmp_arm = 1'b1;
        do_reset();
        wait_head(8'h05, 60);
        stall = 1'b1;
        run(2);
        stall = 1'b0;
        @(posedge clk);
        #1 jmp_arm = 1'b0;
        @(negedge clk);
        chk("t2_flushed", 32'(o_vld), 32'd0);
        chk("t2_req_inflight", 32'(imem_req), 32'd1);
        run(30);
        chk_log("t2_pre", 4, 8'h04, 16'h1004);
        chk_log("t2_target", 5, 8'h03, 16'h1003);
        chk_log("t2_after", 6, 8'h04, 16'h1004);

        // Long memory latency: bubbles between words.
        load_seq(16'h2000);
        mem[3] = 16'h0001; mem_lat = 4;
        do_reset();
        run(2);
        chk("t3_gap_vld", 32'(o_vld), 32'd0);
        chk("t3_gap_o", 32'(o), 32'h0000);
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", 32'(imem_addr), 32'h00);
        run(40);
        chk("t3_log_size", 32'(lg.size()), 32'd4);
        chk_log("t3_w1", 1, 8'h01, 16'h2001);

        // Stall with a full FIFO, then resume in order.
        load_seq(16'h4000);
        mem[6] = 16'h0001; mem_lat = 1; stall = 1'b1;
        do_reset();
        run(10);
        chk("t4_req_full", 32'(imem_req), 32'd0);
        chk("t4_o", 32'(o), 32'h4000);
        run(3);
        chk("t4_req_full2", 32'(imem_req), 32'd0);
        chk("t4_o_stable", 32'(o), 32'h4000);
        chk("t4_pc_stable", 32'(pc_o), 32'h00);
        stall = 1'b0;
        run(30);
        chk_log("t4_w0", 0, 8'h00, 16'h4000);
        chk_log("t4_w1", 1, 8'h01, 16'h4001);
        chk_log("t4_w2", 2, 8'h02, 16'h4002);

        // Absolute jump to 0xFE, then sequential wrap through 0xFF to 0x00.
        load_seq(16'h5000);
        mem[8'h01] = 16'h0001;
        jmp_pc = 8'h00; pcs = 1'b0; jv = 8'hFE; alu_y = 8'h77; jmp_arm = 1'b1;
        do_reset();
        wait_head(8'h00, 20);
        @(posedge clk);
        #1 jmp_arm = 1'b0;
        run(30);
        chk("t5_log_size", 32'(lg.size()), 32'd4);
        chk_log("t5_fe", 0, 8'hFE, 16'h50FE);
        chk_log("t5_ff", 1, 8'hFF, 16'h50FF);
        chk_log("t5_00", 2, 8'h00, 16'h5000);

        // Reset while a request is outstanding; a late ack must be ignored.
        load_seq(16'h6000);
        mem_lat = 6;
        do_reset();
        run(2);
        chk("t6_wait", 32'(imem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; force_ack = 1'b1; force_rdata = 16'hBEEF;
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_addr", 32'(imem_addr), 32'h00);
        chk("t6_rst_o", 32'(o), 32'h0000);
        chk("t6_rst_vld", 32'(o_vld), 32'd0);
        chk("t6_rst_pc", 32'(pc_o), 32'h00);
        chk("t6_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        force_ack = 1'b0;
        chk("t6_req_after", 32'(imem_req), 32'd1);
        chk("t6_addr_after", 32'(imem_addr), 32'h00);
        chk("t6_vld_after", 32'(o_vld), 32'd0);
        lg.delete();
        run(20);
        chk_log("t6_first", 0, 8'h00, 16'h6000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage; sits directly upstream of the instruction decoder.
- Holds the PC and issues reads to instruction memory, which has variable latency.
- Buffers returned words in a small prefetch FIFO and presents the head word to the decoder as `o`.
- Consumes the decoder's `pcwe`, `pcs` and `h` outputs to handle jump redirect, flush and halt.

Parameters:
- AW, 8: PC / instruction-memory address width.
- IW, 16: instruction width; must equal the decoder's command width.
- DEPTH, 2: prefetch FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request; held until `imem_ack`.
- imem_addr  out  AW  read address; stable while `imem_req`=1.
- imem_ack  in  1  one-cycle response strobe; `imem_rdata` is valid with it.
- imem_rdata  in  IW  instruction word returned by memory.
- stall  in  1  back-end hold; the head instruction is not retired.
- o  out  IW  instruction to the decoder; bubble = 16'h0000 (NOP).
- o_vld  out  1  `o` is a real instruction from the FIFO head.
- pc_o  out  AW  address of the head instruction (used for PC-relative jumps).
- pcwe  in  1  decoder: taken jump from the head instruction.
- pcs  in  1  decoder: jump target select (1 = `alu_y`, 0 = `jv`).
- alu_y  in  AW  ALU result (PC + imm).
- jv  in  AW  absolute jump target.
- h  in  1  decoder halt.
- halted  out  1  core halted.

Behaviour:
- Reset: fpc=0; FIFO empty; no request outstanding; discard flag=0; state=RUN.
- Reset outputs: `imem_req`=0, `imem_addr`=0, `o`=16'h0000, `o_vld`=0, `pc_o`=0, `halted`=0.
- Reset mid-request: a later `imem_ack` is ignored.
- States: RUN (no request outstanding), WAIT (one request outstanding), HALT. At most one outstanding request.
- RUN→WAIT: taken when (FIFO count + 0) < DEPTH and no redirect/halt this cycle. Drive `imem_req`=1 and `imem_addr`=fpc registered.
- WAIT→RUN on `imem_ack`:
  - If discard=0: push {fpc, `imem_rdata`}; fpc ← fpc+1, modulo 2^AW (wraps 0xFF→0x00).
  - If discard=1: drop the word and clear discard.
- A new request may issue the cycle after the ack, giving 2-cycle minimum throughput per word with 1-cycle memory.
- FIFO head drives `o` and `pc_o` combinationally, with `o_vld`=1.
- FIFO empty: `o`=0x0000, `o_vld`=0, `pc_o` = fpc.
- Retire: the head pops at the edge when `o_vld`=1 and `stall`=0 and there is no redirect.
- Push and pop in the same cycle: allowed; count unchanged.
- Full FIFO: no request is issued.
- Redirect: when `o_vld`=1, `stall`=0 and `pcwe`=1, at the next edge:
  - flush the FIFO;
  - fpc ← (`pcs` ? `alu_y` : `jv`);
  - if in WAIT, set discard=1;
  - state returns to RUN or stays WAIT.
  - The first word at the target appears at the earliest 2 cycles after the redirect edge.
- `pcwe` with `o_vld`=0 or `stall`=1: ignored.
- Redirect and an ack in the same cycle: the acked word is dropped, the flush happens and fpc = target; discard stays 0.
- Halt: when `o_vld`=1, `stall`=0 and `h`=1, at the next edge:
  - state=HALT and `halted`=1;
  - the head word is held, so `o` keeps presenting the HALT word with `o_vld`=1;
  - no further requests are issued and any in-flight ack is ignored;
  - fpc is frozen.
- Leaving HALT: only `rst` exits HALT.
- `h` and `pcwe` together: cannot both be 1 from the decoder; if forced, halt wins.
- `imem_ack` with no request outstanding: ignored.

Test Plan:
- Reset, memory with 1-cycle ack, image 0x0000:0x8A12, 0x0001:0x8E34, 0x0002:0x0001 -> `o` sequence 0x8A12 (pc_o=0), 0x8E34 (pc_o=1), 0x0001; `halted`=1 one cycle after HALT is at the head; `imem_req` stays 0 afterwards.
- Relative jump at pc 0x05 with `pcwe`=1, `pcs`=1, `alu_y`=0x03 while a fetch of 0x06 is outstanding -> 0x06 word discarded, next `o_vld` word has pc_o=0x03, FIFO flushed.
- Memory ack latency 4 cycles -> `o_vld`=0 and `o`=0x0000 during gaps; exactly one request outstanding at any time.
- `stall`=1 for 3 cycles with FIFO full (DEPTH=2) -> `imem_req`=0, `o`/`pc_o` stable; resumes in order after `stall`=0.
- Sequential fetch from 0xFE -> pc_o 0xFE, 0xFF, 0x00 (wrap).
- `rst` asserted while in WAIT, late ack arrives -> ack ignored, first request after reset to address 0x00, outputs at reset values.
